// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory requester: op encodings, FSM states
// and default bus widths.
package dmem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_READ8   = 2'b00,
    OP_READ16  = 2'b01,
    OP_WRITE16 = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    RD_LAST,
    WR,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_requester_if.sv
// Client request/response handshake plus the byte-memory port of the requester.
// The slave modport is the requester's view; master is the client/memory side.
interface dmem_requester_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);

  logic                    req_valid;
  logic                    req_ready;
  logic [1:0]              req_op;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;

  logic                    resp_valid;
  logic                    resp_ready;
  logic [2*DATA_WIDTH-1:0] resp_rdata;
  logic                    resp_err;

  logic                    mem_we;
  logic [2*DATA_WIDTH-1:0] mem_w_data;
  logic [ADDR_WIDTH-1:0]   mem_w_addr;
  logic [ADDR_WIDTH-1:0]   mem_r_addr;
  logic [DATA_WIDTH-1:0]   mem_r_data;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_r_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_we, mem_w_data, mem_w_addr, mem_r_addr
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_r_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_we, mem_w_data, mem_w_addr, mem_r_addr
  );

endinterface

// File: rtl/dmem_requester.sv
// Non-pipelined byte-memory requester serving READ8/READ16/WRITE16 requests.
// Define DMEM_BOUNDS_CHECK_EN to reject 16-bit accesses at the top address.
module dmem_requester
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  dmem_requester_if.slave bus
);

  state_e                  state;
  op_e                     op_q;
  op_e                     req_op;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    resp_valid_q;
  logic [2*DATA_WIDTH-1:0] resp_rdata_q;
  logic                    resp_err_q;
  logic                    mem_we_q;
  logic [2*DATA_WIDTH-1:0] mem_w_data_q;
  logic [ADDR_WIDTH-1:0]   mem_w_addr_q;
  logic [ADDR_WIDTH-1:0]   mem_r_addr_q;
  logic                    bounds_err;

  assign req_op = op_e'(bus.req_op);

`ifdef DMEM_BOUNDS_CHECK_EN
  // A 16-bit access at the last address would need a byte beyond the memory.
  assign bounds_err = ((req_op == OP_READ16) || (req_op == OP_WRITE16)) && (&bus.req_addr);
`else
  assign bounds_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= OP_READ8;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_w_data_q <= '0;
      mem_w_addr_q <= '0;
      mem_r_addr_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q         <= req_op;
            addr_q       <= bus.req_addr;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            if ((req_op == OP_RSVD) || bounds_err) begin
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state        <= RESP;
            end else if (req_op == OP_WRITE16) begin
              mem_we_q     <= 1'b1;
              mem_w_addr_q <= bus.req_addr;
              mem_w_data_q <= bus.req_wdata;
              state        <= WR;
            end else begin
              mem_r_addr_q <= bus.req_addr;
              state        <= RD_LO;
            end
          end
        end
        RD_LO: begin
          if (op_q == OP_READ16) begin
            mem_r_addr_q <= addr_q + ADDR_WIDTH'(1);
            state        <= RD_HI;
          end else begin
            state <= RD_LAST;
          end
        end
        RD_HI: begin
          resp_rdata_q[DATA_WIDTH-1:0] <= bus.mem_r_data;
          state                        <= RD_LAST;
        end
        RD_LAST: begin
          // READ16 now sees the byte at addr+1; READ8 still sees the byte at addr.
          if (op_q == OP_READ16) begin
            resp_rdata_q[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.mem_r_data;
          end else begin
            resp_rdata_q <= {{DATA_WIDTH{1'b0}}, bus.mem_r_data};
          end
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        WR: begin
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = rst_n && (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_w_data = mem_w_data_q;
  assign bus.mem_w_addr = mem_w_addr_q;
  assign bus.mem_r_addr = mem_r_addr_q;

endmodule

// File: doc/dmem_requester.md
DMEM_REQUESTER -- requirements
Module: dmem_requester

Interface
REQ-001 Parameter DATA_WIDTH, default 8: memory byte width; the SHALL-level design supports only 8.
REQ-002 Parameter ADDR_WIDTH, default 8: memory address width.
REQ-003 clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 req_valid  input  1: client request present.
REQ-006 req_ready  output  1: request accepted on a clk edge when req_valid&&req_ready.
REQ-007 req_op  input  2: 00 READ8, 01 READ16, 10 WRITE16, 11 reserved.
REQ-008 req_addr  input  ADDR_WIDTH: byte address.
REQ-009 req_wdata  input  2*DATA_WIDTH: write data; low byte goes to addr and high byte to addr+1.
REQ-010 resp_valid  output  1: response present, held until accepted.
REQ-011 resp_ready  input  1: response accepted on a clk edge when resp_valid&&resp_ready.
REQ-012 resp_rdata  output  2*DATA_WIDTH: read data, zero-extended for READ8; 0 for WRITE16 and errors.
REQ-013 resp_err  output  1: the request was rejected and no memory access took place.
REQ-014 mem_we  output  1: memory write enable.
REQ-015 mem_w_data  output  2*DATA_WIDTH: memory write data.
REQ-016 mem_w_addr  output  ADDR_WIDTH: memory write address.
REQ-017 mem_r_addr  output  ADDR_WIDTH: memory read address.
REQ-018 mem_r_data  input  DATA_WIDTH: memory read data, valid one clk after mem_r_addr is presented.

Function
REQ-019 The FSM states SHALL be IDLE, RD_LO, RD_HI, RD_LAST, WR and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE with rst_n high.
REQ-021 On acceptance, the block SHALL register op, addr and wdata.
REQ-022 On acceptance, the next state SHALL be RD_LO for READ8/READ16, WR for WRITE16 and RESP with err=1 for reserved.
REQ-023 In RD_LO, mem_r_addr SHALL be addr; next state is RD_HI for READ16 and RD_LAST for READ8.
REQ-024 In RD_HI, mem_r_addr SHALL be addr+1, modulo 2**ADDR_WIDTH; the block captures mem_r_data as the low byte; next state RD_LAST.
REQ-025 In RD_LAST, the block SHALL capture mem_r_data.
REQ-026 In RD_LAST, the capture is the low byte for READ8 and the high byte for READ16; next state RESP.
REQ-027 In WR, mem_we SHALL be 1 for exactly one cycle, with mem_w_addr=addr and mem_w_data=wdata; next state RESP.
REQ-028 mem_we SHALL be 0 in every state other than WR.
REQ-029 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be stable; on resp_ready the next state is IDLE.
REQ-030 Latency from the acceptance edge to the first cycle with resp_valid=1 SHALL be: READ8 3 cycles, READ16 4 cycles, WRITE16 2 cycles, error 1 cycle.
REQ-031 There SHALL be no pipelining; a new request is accepted no earlier than the cycle after the response is consumed.
REQ-032 Unused memory outputs SHALL hold their last values; mem_r_addr is don't-care outside the RD states.

Reset
REQ-033 While rst_n is low, the block SHALL set state=IDLE, req_ready=0 and resp_valid=0.
REQ-034 While rst_n is low, the block SHALL set resp_rdata=0, resp_err=0, mem_we=0, mem_w_data=0, mem_w_addr=0 and mem_r_addr=0.
REQ-035 Reset asserted mid-operation SHALL abandon the operation with no response.
REQ-036 Reset asserted during WR SHALL force mem_we low immediately (asynchronously).

Configuration
REQ-037 With macro DMEM_BOUNDS_CHECK_EN defined, READ16/WRITE16 with addr==2**ADDR_WIDTH-1 SHALL go to RESP with resp_err=1 and perform no memory access.
REQ-038 Without DMEM_BOUNDS_CHECK_EN, such 16-bit accesses SHALL wrap, so the high byte is at address 0.

Structure
REQ-039 Package dmem_pkg SHALL hold the op encodings, the state enumeration and the DATA_WIDTH/ADDR_WIDTH defaults.
REQ-040 No sub-module is natural; the block SHALL be a single module.

Verification
REQ-041 READ16 at 0x08 with mem[8]=1, mem[9]=2 -> resp_rdata=0x0201, resp_err=0, resp_valid 4 cycles after acceptance.
REQ-042 WRITE16 0xABCD at 0x20, then READ8 0x20 and READ8 0x21 -> one-cycle mem_we pulse; responses 0x00CD then 0x00AB.
REQ-043 READ8 at 0x01 with resp_ready held low 5 cycles -> resp_valid and resp_rdata=0x0003 held stable; req_ready=0 throughout.
REQ-044 READ16 at 0xFF -> with macro, resp_err=1 and no mem access; without macro, resp_rdata={mem[0],mem[0xFF]}.
REQ-045 Reserved op 11 -> resp_err=1 one cycle after acceptance and mem_we never asserted.
REQ-046 rst_n low during WR -> mem_we drops immediately, no response, and req_ready=1 in the first cycle after release.
